cp0_regs: RTL and testbench
===========================

CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0000_0004: exception handler entry address.
REQ-002 Parameter COUNT_DIV, default 1: clk cycles per Count increment, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mfc0  input  1  read request for CP0 register addr.
REQ-006 mtc0  input  1  write wdata into CP0 register addr.
REQ-007 addr  input  5  CP0 register number (instruction rd field).
REQ-008 wdata  input  32  mtc0 write data (GPR rt value).
REQ-009 pc  input  32  address of the excepting instruction.
REQ-010 exception  input  1  one-cycle strobe: syscall/break/teq taken.
REQ-011 eret  input  1  one-cycle strobe: return from exception.
REQ-012 cause  input  5  exception code, valid with exception.
REQ-013 rdata  output  32  CP0 read data to the CPU register-file mux.
REQ-014 status  output  32  current Status register.
REQ-015 exc_addr  output  32  next-PC target for exception entry or eret.
REQ-016 int_req  output  1  timer interrupt request to the CPU control unit.

Function
REQ-017 Implemented registers: Count=9, Compare=11, Status=12, Cause=13, EPC=14; all other addresses read 0 and ignore writes.
REQ-018 rdata = register[addr] combinationally when mfc0=1, else 32'h0.
REQ-019 mtc0=1 writes wdata into register[addr] at the clock edge.
REQ-020 exception=1: Status <= Status<<5; Cause[6:2] <= cause, other Cause bits unchanged; EPC <= pc.
REQ-021 eret=1 with exception=0: Status <= Status>>5; EPC unchanged.
REQ-022 exc_addr = EPC when eret=1, HANDLER_ADDR otherwise (combinational).
REQ-023 Prescaler counts 0..COUNT_DIV-1; on reaching COUNT_DIV-1 it returns to 0 and Count increments by 1, wrapping 32'hFFFF_FFFF -> 0.
REQ-024 Cycle after Count becomes equal to Compare (nonzero Compare), Cause[15] (IP7) <= 1; it stays 1 until cleared.
REQ-025 mtc0 to Compare clears Cause[15] in the same edge.
REQ-026 int_req = Status[0] & Status[15] & Cause[15].
REQ-027 exception and eret in the same cycle: exception wins, eret ignored.
REQ-028 mtc0 to Status/Cause/EPC in the same cycle as exception: the exception update wins, the write is dropped.
REQ-029 mtc0 to Count in the same cycle as an increment: written value wins; the prescaler resets to 0.
REQ-030 Compare match and a Compare write in the same cycle: the clear wins.

Reset
REQ-031 rst low asynchronously clears Count, Compare, Status, Cause, EPC and the prescaler to 0.
REQ-032 Reset values of outputs: rdata=0, status=0, int_req=0, exc_addr=HANDLER_ADDR.
REQ-033 Reset during an exception or eret strobe leaves all registers at reset values; nothing is committed.

Structure
REQ-034 Package cp0_pkg holds the register-number constants (9, 11, 12, 13, 14), the cause codes (SYSCALL=5'b01000, BREAK=5'b01001, TEQ=5'b01101) and the IP7 bit index.
REQ-035 Sub-module cp0_timer holds Count, Compare, the prescaler and match detection; cp0_regs holds Status/Cause/EPC and the muxing.
REQ-036 Size target: 150-250 lines total.

Verification
REQ-037 mtc0 Status=32'h0000_8001, then exception with cause=5'b01000, pc=32'h0040_0010 -> status=32'h0010_0020, Cause[6:2]=8, EPC=32'h0040_0010, exc_addr=HANDLER_ADDR.
REQ-038 Following the above, eret -> status=32'h0000_8001, exc_addr=32'h0040_0010 in the eret cycle.
REQ-039 COUNT_DIV=1, Compare=5, Count=0, Status=32'h0000_8001 -> int_req rises 1 cycle after Count reaches 5; mtc0 Compare=100 -> int_req=0 next cycle.
REQ-040 Count=32'hFFFF_FFFF, one increment -> Count=0, no spurious IP7 with Compare=0.
REQ-041 exception+eret together, and exception with mtc0 EPC=32'h1234 -> EPC=pc, Status shifted left once.
REQ-042 Assert rst mid-count -> all outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception cause codes and the
// Cause bit that carries the timer interrupt pending flag.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  typedef enum logic [4:0] {
    EXC_SYSCALL = 5'b01000,
    EXC_BREAK   = 5'b01001,
    EXC_TEQ     = 5'b01101
  } exc_code_e;

  localparam int IP7_BIT = 15;

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaled free-running Count, Compare register and the
// Count==Compare match flag consumed by the Cause register.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match
);

  localparam logic [7:0] DIV_LAST = 8'(COUNT_DIV - 1);

  logic [7:0] presc;
  logic       tick;

  assign tick  = (presc == DIV_LAST);
  // Compare==0 is treated as "timer disarmed" so a wrapped Count cannot fire.
  assign match = (count == compare) && (compare != 32'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= 8'h0;
      count   <= 32'h0;
      compare <= 32'h0;
    end else begin
      if (wr_count) begin
        count <= wdata;
        presc <= 8'h0;
      end else if (tick) begin
        count <= count + 32'd1;
        presc <= 8'h0;
      end else begin
        presc <= presc + 8'd1;
      end
      if (wr_compare) compare <= wdata;
    end
  end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: Status/Cause/EPC, exception entry/return sequencing,
// mfc0 read mux and timer interrupt request.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
  parameter int          COUNT_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        exception,
  input  logic        eret,
  input  logic [4:0]  cause,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] exc_addr,
  output logic        int_req
);

  logic [31:0] cause_reg;
  logic [31:0] cause_next;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = mtc0 && (addr == REG_COUNT);
  assign wr_compare = mtc0 && (addr == REG_COMPARE);
  assign wr_status  = mtc0 && (addr == REG_STATUS);
  assign wr_cause   = mtc0 && (addr == REG_CAUSE);
  assign wr_epc     = mtc0 && (addr == REG_EPC);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_count),
    .wr_compare (wr_compare),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .match      (match)
  );

  // IP7 is owned by the timer path: a Compare write clears it even if the
  // match is live in the same cycle, and it is independent of exception entry.
  always_comb begin
    cause_next = cause_reg;
    if (exception)
      cause_next[6:2] = cause;
    else if (wr_cause)
      cause_next = wdata;
    if (wr_compare)
      cause_next[IP7_BIT] = 1'b0;
    else if (match)
      cause_next[IP7_BIT] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status    <= 32'h0;
      cause_reg <= 32'h0;
      epc       <= 32'h0;
    end else begin
      if (exception) begin
        status <= status << 5;
        epc    <= pc;
      end else begin
        if (eret)
          status <= status >> 5;
        else if (wr_status)
          status <= wdata;
        if (wr_epc)
          epc <= wdata;
      end
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (mfc0) begin
      case (addr)
        REG_COUNT:   rdata = count;
        REG_COMPARE: rdata = compare;
        REG_STATUS:  rdata = status;
        REG_CAUSE:   rdata = cause_reg;
        REG_EPC:     rdata = epc;
        default:     rdata = 32'h0;
      endcase
    end
  end

  // A simultaneous exception overrides eret, including the redirect target.
  assign exc_addr = (eret && !exception) ? epc : HANDLER_ADDR;
  assign int_req  = status[0] & status[15] & cause_reg[IP7_BIT];

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: vector table plus hand sequences for
// timer, wrap, same-cycle priority and asynchronous reset behaviour.
module tb_cp0_regs;
  import cp0_pkg::*;

  localparam logic [31:0] H = 32'h0000_0004;

  logic        clk, rst;
  logic        mfc0, mtc0, exception, eret;
  logic [4:0]  addr, cause;
  logic [31:0] wdata, pc;
  logic [31:0] rdata, status, exc_addr;
  logic        int_req;
  logic [31:0] rdata2, status2, exc_addr2;
  logic        int_req2;

  cp0_regs #(.HANDLER_ADDR(H), .COUNT_DIV(1)) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .addr(addr),
    .wdata(wdata), .pc(pc), .exception(exception), .eret(eret),
    .cause(cause), .rdata(rdata), .status(status), .exc_addr(exc_addr),
    .int_req(int_req)
  );

  cp0_regs #(.HANDLER_ADDR(H), .COUNT_DIV(3)) dut_div3 (
    .clk(clk), .rst(rst), .mfc0(1'b1), .mtc0(1'b0), .addr(5'd9),
    .wdata(32'h0), .pc(32'h0), .exception(1'b0), .eret(1'b0),
    .cause(5'h0), .rdata(rdata2), .status(status2), .exc_addr(exc_addr2),
    .int_req(int_req2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic mfc0, mtc0;
    logic [4:0] addr;
    logic [31:0] wdata, pc;
    logic exc, eret;
    logic [4:0] code;
    logic [31:0] e_rdata, e_status, e_exc;
    logic e_int;
    bit   chk_exc;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  vec_t vecs[23];
  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic m_f, logic m_t, logic [4:0] a, logic [31:0] wd,
                              logic [31:0] p, logic ex, logic er, logic [4:0] cd,
                              logic [31:0] r, logic [31:0] s, logic [31:0] x,
                              logic i, bit ce);
    vec_t v;
    v.mfc0 = m_f; v.mtc0 = m_t; v.addr = a; v.wdata = wd; v.pc = p;
    v.exc = ex; v.eret = er; v.code = cd;
    v.e_rdata = r; v.e_status = s; v.e_exc = x; v.e_int = i; v.chk_exc = ce;
    return v;
  endfunction

  task automatic idle();
    mfc0 = 1'b0; mtc0 = 1'b0; addr = 5'd0; wdata = 32'h0; pc = 32'h0;
    exception = 1'b0; eret = 1'b0; cause = 5'd0;
  endtask

  task automatic drive(input vec_t v);
    mfc0 = v.mfc0; mtc0 = v.mtc0; addr = v.addr; wdata = v.wdata; pc = v.pc;
    exception = v.exc; eret = v.eret; cause = v.code;
  endtask

  // sel: 0 rdata, 1 status, 2 exc_addr, 3 int_req, 4 div-3 instance rdata
  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        0:       got = rdata;
        1:       got = status;
        2:       got = exc_addr;
        3:       got = {31'h0, int_req};
        default: got = rdata2;
      endcase
      total++;
      if (got !== e.val)
        $display("FAIL %s sel%0d: got %h, expected %h", e.name, e.sel, got, e.val);
      else
        passed++;
    end
  endtask

  task automatic rd(input logic [4:0] a);
    idle(); mfc0 = 1'b1; addr = a;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle(); mtc0 = 1'b1; addr = a; wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0,1,REG_STATUS,32'h8001,0,0,0,0,          0,32'h8001*0,H,0,1);
    vecs[1]  = mk(1,0,REG_STATUS,0,0,0,0,0,                 32'h8001,32'h8001,H,0,1);
    vecs[2]  = mk(0,0,0,0,32'h0040_0010,1,0,EXC_SYSCALL,    0,32'h8001,H,0,1);
    vecs[3]  = mk(1,0,REG_STATUS,0,0,0,0,0,                 32'h0010_0020,32'h0010_0020,H,0,1);
    vecs[4]  = mk(1,0,REG_CAUSE,0,0,0,0,0,                  32'h20,32'h0010_0020,H,0,1);
    vecs[5]  = mk(1,0,REG_EPC,0,0,0,0,0,                    32'h0040_0010,32'h0010_0020,H,0,1);
    vecs[6]  = mk(1,0,REG_EPC,0,0,0,1,0,                    32'h0040_0010,32'h0010_0020,32'h0040_0010,0,1);
    vecs[7]  = mk(1,0,REG_STATUS,0,0,0,0,0,                 32'h8001,32'h8001,H,0,1);
    vecs[8]  = mk(1,1,5'd5,32'hFFFF,0,0,0,0,                0,32'h8001,H,0,1);
    vecs[9]  = mk(0,0,REG_STATUS,0,0,0,0,0,                 0,32'h8001,H,0,1);
    vecs[10] = mk(0,0,0,0,32'h500,1,1,EXC_BREAK,            0,32'h8001,H,0,0);
    vecs[11] = mk(1,0,REG_STATUS,0,0,0,0,0,                 32'h0010_0020,32'h0010_0020,H,0,1);
    vecs[12] = mk(1,0,REG_CAUSE,0,0,0,0,0,                  32'h24,32'h0010_0020,H,0,1);
    vecs[13] = mk(1,0,REG_EPC,0,0,0,0,0,                    32'h500,32'h0010_0020,H,0,1);
    vecs[14] = mk(0,1,REG_EPC,32'h1234,32'h600,1,0,EXC_TEQ, 0,32'h0010_0020,H,0,1);
    vecs[15] = mk(1,0,REG_EPC,0,0,0,0,0,                    32'h600,32'h0200_0400,H,0,1);
    vecs[16] = mk(1,0,REG_CAUSE,0,0,0,0,0,                  32'h34,32'h0200_0400,H,0,1);
    vecs[17] = mk(0,1,REG_STATUS,32'hFFFF,32'h700,1,0,EXC_SYSCALL, 0,32'h0200_0400,H,0,1);
    vecs[18] = mk(1,0,REG_STATUS,0,0,0,0,0,                 32'h4000_8000,32'h4000_8000,H,0,1);
    vecs[19] = mk(0,1,REG_CAUSE,32'h300,0,0,0,0,            0,32'h4000_8000,H,0,1);
    vecs[20] = mk(1,0,REG_CAUSE,0,0,0,0,0,                  32'h300,32'h4000_8000,H,0,1);
    vecs[21] = mk(0,1,REG_EPC,32'hABCD,0,0,0,0,             0,32'h4000_8000,H,0,1);
    vecs[22] = mk(1,0,REG_EPC,0,0,0,0,0,                    32'hABCD,32'h4000_8000,H,0,1);

    // reset state
    idle(); rst = 1'b0;
    mfc0 = 1'b1; addr = REG_STATUS;
    #2;
    push("rst_rdata", 0, 32'h0); push("rst_status", 1, 32'h0);
    push("rst_exc", 2, H);       push("rst_int", 3, 32'h0);
    drain();
    @(negedge clk); @(negedge clk);
    rst = 1'b1; idle();

    // prescaler with COUNT_DIV=3
    @(negedge clk); @(negedge clk);
    #1 push("div3_e2", 4, 32'd0); drain();
    @(negedge clk);
    #1 push("div3_e3", 4, 32'd1); drain();
    repeat (3) @(negedge clk);
    #1 push("div3_e6", 4, 32'd2); drain();

    // vector table
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      push($sformatf("vec%0d_rdata", i), 0, vecs[i].e_rdata);
      push($sformatf("vec%0d_status", i), 1, vecs[i].e_status);
      if (vecs[i].chk_exc) push($sformatf("vec%0d_exc", i), 2, vecs[i].e_exc);
      push($sformatf("vec%0d_int", i), 3, {31'h0, vecs[i].e_int});
      drain();
    end

    // timer interrupt: Compare=5, Count=0
    @(negedge clk) wr(REG_STATUS, 32'h8001);
    @(negedge clk) wr(REG_COMPARE, 32'd5);
    @(negedge clk) wr(REG_COUNT, 32'd0);
    @(negedge clk) rd(REG_COUNT);
    #2 push("tmr_count0", 0, 32'd0); drain();
    repeat (5) @(negedge clk);
    #2 push("tmr_count5", 0, 32'd5); push("tmr_int_at5", 3, 32'h0); drain();
    @(negedge clk);
    #2 push("tmr_count6", 0, 32'd6); push("tmr_int_rise", 3, 32'h1); drain();
    @(negedge clk) rd(REG_CAUSE);
    #2 push("tmr_cause_ip7", 0, 32'h8300); push("tmr_int_hold", 3, 32'h1); drain();
    @(negedge clk) wr(REG_COMPARE, 32'd100);
    #2 push("tmr_int_before_clr", 3, 32'h1); drain();
    @(negedge clk) idle();
    #2 push("tmr_int_cleared", 3, 32'h0); drain();

    // wrap with Compare=0
    @(negedge clk) wr(REG_COMPARE, 32'd0);
    @(negedge clk) wr(REG_COUNT, 32'hFFFF_FFFF);
    @(negedge clk) rd(REG_COUNT);
    #2 push("wrap_max", 0, 32'hFFFF_FFFF); drain();
    @(negedge clk);
    #2 push("wrap_zero", 0, 32'h0); drain();
    @(negedge clk) rd(REG_CAUSE);
    #2 push("wrap_no_ip7", 0, 32'h300); push("wrap_int", 3, 32'h0); drain();

    // match coincides with Compare write: clear wins
    @(negedge clk) wr(REG_COMPARE, 32'd60);
    @(negedge clk) wr(REG_COUNT, 32'd55);
    @(negedge clk) rd(REG_COUNT);
    #2 push("coll_count55", 0, 32'd55); drain();
    repeat (5) @(negedge clk);
    wr(REG_COMPARE, 32'd200); mfc0 = 1'b1;
    #2 push("coll_compare", 0, 32'd60); drain();
    @(negedge clk) rd(REG_CAUSE);
    #2 push("coll_no_ip7", 0, 32'h300); push("coll_int", 3, 32'h0); drain();

    // asynchronous reset mid-count, with eret then exception strobes held
    @(negedge clk) rd(REG_COUNT); eret = 1'b1;
    #3 rst = 1'b0;
    #1 push("arst_rdata", 0, 32'h0); push("arst_status", 1, 32'h0);
    push("arst_int", 3, 32'h0); drain();
    eret = 1'b0; exception = 1'b1; pc = 32'h777; cause = EXC_SYSCALL;
    #1 push("arst_exc", 2, H); drain();
    @(negedge clk) rst = 1'b1; rd(REG_EPC);
    #2 push("arst_epc", 0, 32'h0); push("arst_status2", 1, 32'h0); drain();
    @(negedge clk) rd(REG_CAUSE);
    #2 push("arst_cause", 0, 32'h0); drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
